// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: Moore state decode plus ALU control decode.
// Optional bne support is enabled by defining MULTICYCLE_CONTROLLER_BNE_EN.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       PCEn,
  output logic [3:0] State
);

  localparam int unsigned OPW = 6;

  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, branch, branch_ne;
  logic       ir_write_s, mem_write_s, reg_write_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = FETCH;
    IorD        = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    alu_op      = 2'b00;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    case (state_q)
      FETCH: begin
        state_d    = DECODE;
        ir_write_s = 1'b1;
        pc_write   = 1'b1;
        ALUSrcB    = 2'b01;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: begin
        state_d = MEMWB;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        IorD        = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTE: begin
        state_d = ALUWB;
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        reg_write_s = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
        // Opcode is held until FETCH, so it still tells beq from bne here
        branch_ne = (Opcode == OP_BNE);
        branch    = (Opcode != OP_BNE);
`else
        branch    = 1'b1;
`endif
      end
      ADDIEXEC: begin
        state_d = ADDIWB;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        reg_write_s = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU control decode
  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // Write enables are held off while reset is asserted
  assign PCEn     = ~reset & (pc_write | (branch & Zero) | (branch_ne & ~Zero));
  assign IRWrite  = ~reset & ir_write_s;
  assign MemWrite = ~reset & mem_write_s;
  assign RegWrite = ~reset & reg_write_s;
  assign State    = state_q;

endmodule
